// File: rtl/avalon_latency_bridge.sv
// avalon_latency_bridge
// Presents a fixed 1-cycle read latency to the clarvi core in front of a
// variable-latency, waitrequest-capable pipelined Avalon-MM slave. One
// transaction is in flight at a time; hung reads are cut off by a timeout
// that returns zero data and raises a sticky bus_error.
module avalon_latency_bridge #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   avs_address,
    input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [DATA_WIDTH-1:0]   avs_writedata,
    output logic [DATA_WIDTH-1:0]   avs_readdata,
    output logic                    avs_readdatavalid,
    output logic                    avs_waitrequest,
    output logic [ADDR_WIDTH-1:0]   avm_address,
    output logic [DATA_WIDTH/8-1:0] avm_byteenable,
    output logic                    avm_read,
    output logic                    avm_write,
    output logic [DATA_WIDTH-1:0]   avm_writedata,
    input  logic [DATA_WIDTH-1:0]   avm_readdata,
    input  logic                    avm_readdatavalid,
    input  logic                    avm_waitrequest,
    output logic                    bus_error
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        ACCEPT
    } state_t;

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [BE_WIDTH-1:0]   be_q,     be_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic                  is_read_q, is_read_d;
    logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] hold_q,   hold_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q,    err_d;

    // State and datapath registers; synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            cnt_q     <= '0;
            hold_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: latch request, issue downstream, wait for data, accept.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (avs_read || avs_write) begin
                    addr_d    = avs_address;
                    be_d      = avs_byteenable;
                    wdata_d   = avs_writedata;
                    // A simultaneous read and write is treated as a read.
                    is_read_d = avs_read;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest) begin
                    if (is_read_q) begin
                        cnt_d   = '0;
                        state_d = WAIT_DATA;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            WAIT_DATA: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                if (avm_readdatavalid) begin
                    hold_d  = avm_readdata;
                    state_d = ACCEPT;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    hold_d  = '0;
                    err_d   = 1'b1;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                state_d = IDLE;
                if (is_read_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = hold_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign avs_waitrequest   = (avs_read | avs_write) & (state_q != ACCEPT);
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign bus_error         = err_q;

    // Gated by reset so the downstream request drops in the reset cycle itself,
    // not one cycle later when the state register clears.
    assign avm_read       = (state_q == ISSUE) & is_read_q & ~reset;
    assign avm_write      = (state_q == ISSUE) & ~is_read_q & ~reset;
    assign avm_address    = addr_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_avalon_latency_bridge.sv
// Testbench for avalon_latency_bridge: a scripted/randomised core master, a
// slave model with per-transaction waitrequest and read latency, and a
// transaction-level model predicting acceptance cycle, response and bus_error.
module tb_avalon_latency_bridge;

    localparam int          AW = 14;
    localparam int          DW = 64;
    localparam int          BW = DW / 8;
    localparam int unsigned T  = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] avs_address = '0;
    logic [BW-1:0] avs_byteenable = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [DW-1:0] avs_writedata = '0;
    logic [DW-1:0] avs_readdata;
    logic          avs_readdatavalid;
    logic          avs_waitrequest;
    logic [AW-1:0] avm_address;
    logic [BW-1:0] avm_byteenable;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;
    logic          avm_waitrequest = 1'b0;
    logic          bus_error;

    avalon_latency_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .avs_address      (avs_address),
        .avs_byteenable   (avs_byteenable),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avs_waitrequest  (avs_waitrequest),
        .avm_address      (avm_address),
        .avm_byteenable   (avm_byteenable),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest  (avm_waitrequest),
        .bus_error        (bus_error)
    );

    // One downstream beat as the master intends it, plus how the slave answers.
    typedef struct {
        bit            rd;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdval;
        int unsigned   w;      // waitrequest cycles before the slave accepts
        int unsigned   l;      // read data latency, 0 = never answers
        int unsigned   start;  // core cycle in which the request was raised
    } beat_t;

    typedef struct {
        int unsigned   cyc;
        logic [DW-1:0] data;
    } pulse_t;

    beat_t         beats[$];
    pulse_t        pulses[$];
    int unsigned   cyc = 0;
    int unsigned   tests = 0;
    int unsigned   fails = 0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err = 1'b0;
    bit            s_busy = 1'b0;
    int unsigned   s_wleft = 0;
    bit            s_pend = 1'b0;
    int unsigned   s_pend_cyc = 0;
    logic [DW-1:0] s_pend_data = '0;

    // Free-running clock and cycle counter.
    always #5 clock = ~clock;

    // Cycle index, stable between posedges.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Slave model: answers beats, checks their fields, holds waitrequest.
    initial begin
        beat_t b;
        forever begin
            @(negedge clock);
            #1;
            if (s_pend && s_pend_cyc == cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = s_pend_data;
                s_pend            = 1'b0;
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = {$urandom, $urandom};
            end
            if (reset) begin
                chk("avm quiet in reset", DW'({avm_read, avm_write}), '0);
                beats.delete();
                s_busy          = 1'b0;
                avm_waitrequest = 1'($urandom_range(0, 1));
            end else if (avm_read || avm_write) begin
                if (beats.size() == 0) begin
                    chk("unexpected avm beat", DW'(1), DW'(0));
                    avm_waitrequest = 1'b0;
                end else begin
                    b = beats[0];
                    if (!s_busy) begin
                        s_busy  = 1'b1;
                        s_wleft = b.w;
                        chk("avm issue cycle", DW'(cyc), DW'(b.start + 1));
                    end
                    chk("avm_read", DW'(avm_read), DW'(b.rd));
                    chk("avm_write", DW'(avm_write), DW'(!b.rd));
                    chk("avm_address", DW'(avm_address), DW'(b.addr));
                    chk("avm_byteenable", DW'(avm_byteenable), DW'(b.be));
                    chk("avm_writedata", avm_writedata, b.wdata);
                    if (s_wleft > 0) begin
                        avm_waitrequest = 1'b1;
                        s_wleft--;
                    end else begin
                        avm_waitrequest = 1'b0;
                        s_busy = 1'b0;
                        void'(beats.pop_front());
                        if (b.rd && b.l != 0) begin
                            s_pend      = 1'b1;
                            s_pend_cyc  = cyc + b.l;
                            s_pend_data = b.rdval;
                        end
                    end
                end
            end else begin
                if (s_busy) chk("avm request dropped before accept", DW'(0), DW'(1));
                s_busy          = 1'b0;
                avm_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    // Compare process: core-side response and bus_error against the model every cycle.
    initial begin
        bit ev;
        forever begin
            @(negedge clock);
            #3;
            if (reset) begin
                m_err   = 1'b0;
                m_rdata = '0;
                pulses.delete();
            end else begin
                ev = 1'b0;
                if (pulses.size() != 0 && pulses[0].cyc == cyc) begin
                    ev      = 1'b1;
                    m_rdata = pulses[0].data;
                    void'(pulses.pop_front());
                end
                chk("avs_readdatavalid", DW'(avs_readdatavalid), DW'(ev));
                chk("avs_readdata", avs_readdata, m_rdata);
                chk("bus_error", DW'(bus_error), DW'(m_err));
            end
        end
    end

    task automatic start_req(input bit rd, input logic [AW-1:0] a, input logic [BW-1:0] be,
                             input logic [DW-1:0] wd, input logic [DW-1:0] rv,
                             input int unsigned w, input int unsigned l, output int unsigned s);
        beat_t b;
        avs_read       = rd;
        avs_write      = !rd;
        avs_address    = a;
        avs_byteenable = be;
        avs_writedata  = wd;
        s       = cyc;
        b.rd    = rd;
        b.addr  = a;
        b.be    = be;
        b.wdata = wd;
        b.rdval = rv;
        b.w     = w;
        b.l     = l;
        b.start = s;
        beats.push_back(b);
    endtask

    // Full core transaction; called at a negedge, returns at the negedge after acceptance.
    task automatic txn(input bit rd, input logic [AW-1:0] a, input logic [BW-1:0] be,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rv,
                       input int unsigned w, input int unsigned l, output int unsigned lat);
        int unsigned s;
        int unsigned exp_acc;
        bit          to;
        bit          got;
        pulse_t      p;
        start_req(rd, a, be, wd, rv, w, l, s);
        to      = rd && (l == 0 || l > T);
        exp_acc = s + 2 + w + (rd ? (to ? T : l) : 0);
        got     = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #2;
            if (!avs_waitrequest) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("accepted within bound", DW'(got), DW'(1));
        lat = cyc - s;
        if (got) begin
            chk("accept cycle", DW'(cyc), DW'(exp_acc));
            if (rd) begin
                p.cyc  = cyc + 1;
                p.data = to ? '0 : rv;
                pulses.push_back(p);
            end
            if (to) m_err = 1'b1;
        end
        @(negedge clock);
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    // Directed scenarios followed by randomised traffic.
    initial begin
        int unsigned   lat;
        int unsigned   s;
        bit            rd;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #2;
        chk("reset avm_read", DW'(avm_read), '0);
        chk("reset avm_write", DW'(avm_write), '0);
        chk("reset avm_address", DW'(avm_address), '0);
        chk("reset avm_byteenable", DW'(avm_byteenable), '0);
        chk("reset avm_writedata", avm_writedata, '0);
        chk("reset avs_readdatavalid", DW'(avs_readdatavalid), '0);
        chk("reset avs_readdata", avs_readdata, '0);
        chk("reset bus_error", DW'(bus_error), '0);
        chk("reset avs_waitrequest", DW'(avs_waitrequest), '0);
        @(negedge clock);

        // Read, zero-wait slave, 3-cycle data latency.
        txn(1'b1, 14'h0010, 8'hFF, 64'h0, 64'h0123456789ABCDEF, 0, 3, lat);
        chk("read lat3 accept latency", DW'(lat), DW'(5));
        #3;
        chk("read lat3 valid", DW'(avs_readdatavalid), DW'(1));
        chk("read lat3 data", avs_readdata, 64'h0123456789ABCDEF);
        @(negedge clock);

        // Write with 4 waitrequest cycles.
        txn(1'b0, 14'h0020, 8'h0F, 64'hCAFEBABE, 64'h0, 4, 0, lat);
        chk("write wait4 accept latency", DW'(lat), DW'(6));
        #3;
        chk("write no valid", DW'(avs_readdatavalid), DW'(0));
        @(negedge clock);

        // Read that never returns data.
        txn(1'b1, 14'h0040, 8'hFF, 64'h0, 64'h5555, 0, 0, lat);
        chk("timeout accept latency", DW'(lat), DW'(10));
        #3;
        chk("timeout valid", DW'(avs_readdatavalid), DW'(1));
        chk("timeout data", avs_readdata, 64'h0);
        chk("timeout bus_error", DW'(bus_error), DW'(1));
        @(negedge clock);

        // Back-to-back reads A then B.
        txn(1'b1, 14'h0001, 8'hFF, 64'h0, 64'h11, 0, 1, lat);
        chk("read A accept latency", DW'(lat), DW'(3));
        txn(1'b1, 14'h0002, 8'hFF, 64'h0, 64'h22, 0, 1, lat);
        chk("read B accept latency", DW'(lat), DW'(3));
        #3;
        chk("read B data", avs_readdata, 64'h22);
        chk("bus_error sticky", DW'(bus_error), DW'(1));
        @(negedge clock);

        // Stray readdatavalid while idle.
        s_pend      = 1'b1;
        s_pend_cyc  = cyc;
        s_pend_data = 64'hFFFF;
        repeat (2) @(negedge clock);
        #3;
        chk("stray valid ignored", DW'(avs_readdatavalid), DW'(0));
        chk("stray data ignored", avs_readdata, 64'h22);
        @(negedge clock);

        // Reset in WAIT_DATA; data arrives afterwards and is discarded.
        start_req(1'b1, 14'h0030, 8'hFF, 64'h0, 64'hDEAD, 0, 4, s);
        repeat (3) @(negedge clock);
        reset    = 1'b1;
        avs_read = 1'b0;
        #2;
        chk("reset wait_data avm_read", DW'(avm_read), DW'(0));
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #3;
        chk("late data after reset", DW'(avs_readdatavalid), DW'(0));
        chk("bus_error cleared by reset", DW'(bus_error), DW'(0));
        @(negedge clock);

        // Reset while a write is stalled in ISSUE.
        start_req(1'b0, 14'h0031, 8'h3C, 64'h1234, 64'h0, 5, 0, s);
        @(negedge clock);
        reset     = 1'b1;
        avs_write = 1'b0;
        #2;
        chk("reset issue avm_write", DW'(avm_write), DW'(0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            rd = 1'($urandom_range(0, 1));
            txn(rd, AW'($urandom), BW'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 10), lat);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (12) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule

// File: doc/avalon_latency_bridge.md
Name: avalon_latency_bridge

Overview:
- Sits directly downstream of the clarvi Avalon-MM data or instruction master.
- The core supports only fixed 1-cycle read latency, so this bridge gives the core that latency in front of any variable-latency, waitrequest-capable pipelined slave (SDRAM controller, interconnect, peripherals).
- Handles one transaction at a time. It stalls the core with waitrequest until the downstream access completes, then returns read data exactly one cycle after acceptance.
- A timeout turns hung downstream reads into an error response.

Parameters:
ADDR_WIDTH  14  address width, both sides
DATA_WIDTH  64  data width, both sides (byteenable width = DATA_WIDTH/8)
TIMEOUT_CYCLES  255  max cycles waiting for downstream readdatavalid; 0 = no timeout

Ports:
clock  input  1  single clock
reset  input  1  synchronous, active-high reset
avs_address  input  ADDR_WIDTH  core-side address
avs_byteenable  input  DATA_WIDTH/8  core-side byte enables
avs_read  input  1  core read request
avs_write  input  1  core write request
avs_writedata  input  DATA_WIDTH  core write data
avs_readdata  output  DATA_WIDTH  read data to core
avs_readdatavalid  output  1  read data valid, exactly 1 cycle after read acceptance
avs_waitrequest  output  1  stall to core
avm_address  output  ADDR_WIDTH  downstream address
avm_byteenable  output  DATA_WIDTH/8  downstream byte enables
avm_read  output  1  downstream read
avm_write  output  1  downstream write
avm_writedata  output  DATA_WIDTH  downstream write data
avm_readdata  input  DATA_WIDTH  downstream read data
avm_readdatavalid  input  1  downstream read data valid (any latency ≥1)
avm_waitrequest  input  1  downstream stall
bus_error  output  1  sticky; set on read timeout, cleared only by reset

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; all avm_* control outputs 0, avm_address/byteenable/writedata 0; avs_readdatavalid 0; avs_readdata 0; bus_error 0; timeout counter 0.
- Core-side stall: avs_waitrequest = (avs_read | avs_write) & (state != ACCEPT). This is combinational. It is 0 when no request is present.
- A core transaction is accepted in the cycle with request high and avs_waitrequest low.
- States:
  - IDLE: if avs_read or avs_write, register address, byteenable, writedata and kind (read/write); go to ISSUE. avs_read and avs_write both high is illegal; read takes priority.
  - ISSUE: drive avm_read or avm_write with the latched fields. Hold them stable while avm_waitrequest = 1. When avm_waitrequest = 0: a write goes to ACCEPT; a read goes to WAIT_DATA, clears the counter, and drops avm_read the next cycle.
  - WAIT_DATA: increment the counter each cycle.
    - avm_readdatavalid = 1: capture avm_readdata into a holding register; go to ACCEPT.
    - Otherwise, if TIMEOUT_CYCLES ≠ 0 and counter = TIMEOUT_CYCLES-1: holding register := 0; set bus_error; go to ACCEPT.
  - ACCEPT: avs_waitrequest = 0 for exactly this cycle, which accepts the core request. Go to IDLE. For a read, the next cycle has avs_readdatavalid = 1 and avs_readdata = holding register.
- avs_readdatavalid is a single-cycle registered pulse. avs_readdata holds its value until the next read response.
- Minimum latency:
  - Read with zero-wait slave and 1-cycle data: IDLE → ISSUE → WAIT_DATA → ACCEPT, so 4 cycles of request before acceptance.
  - Write: IDLE → ISSUE → ACCEPT, so 3 cycles.
- Back-to-back: the cycle after ACCEPT is IDLE. A new request may start there while avs_readdatavalid for the previous read is high. Both are allowed simultaneously.
- avm_readdatavalid arriving in any state other than WAIT_DATA (stray or post-timeout) is discarded with no output effect.
- Known limitation: a late response arriving after a subsequent read reaches WAIT_DATA is taken as that read's data.
- If the core drops its request before acceptance (protocol violation), behaviour is undefined. The bridge still completes the downstream access.
- Reset mid-operation: immediate return to IDLE and all avm_* deasserted in the reset cycle. The in-flight downstream transaction is abandoned.
- Counter width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Test Plan:
- Read, zero-wait slave, 3-cycle data latency, addr 0x0010 returns 0x0123456789ABCDEF → avm_read for 1 cycle at 0x0010; core accepted after 6 cycles; avs_readdatavalid pulse next cycle with 0x0123456789ABCDEF; bus_error 0.
- Write addr 0x0020, byteenable 0x0F, data 0xCAFEBABE, slave waitrequest high 4 cycles → avm_write/address/byteenable/writedata held stable 5 cycles; core accepted 1 cycle after avm acceptance; no avs_readdatavalid.
- Read, slave never returns data, TIMEOUT_CYCLES = 8 → after 8 WAIT_DATA cycles, core accepted; avs_readdata = 0 with valid pulse; bus_error = 1 and stays 1 through later successful reads.
- Read A (0x0001 → 0x11) then read B (0x0002 → 0x22) back-to-back → B's avm_read issued only after A's valid pulse cycle; core sees 0x11 then 0x22, each valid exactly 1 cycle after its acceptance.
- Stray avm_readdatavalid with 0xFFFF in IDLE → no avs_readdatavalid; avs_readdata unchanged.
- Reset asserted in WAIT_DATA, then data arrives → avm_read 0, state IDLE, response discarded; bus_error 0.
